// File: rtl/bsg_mem_2rw_sync_mask_write_byte_ctrl.sv
// Dual-port request/response front end for a byte-masked sync RAM.
// Arbitrates same-address write collisions and buffers late read data.
module bsg_mem_2rw_sync_mask_write_byte_ctrl #(
  parameter int width_p = 32,
  parameter int els_p = 16,
  parameter int resp_els_p = 3,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     a_v_i,
  input  logic                     a_w_i,
  input  logic [addr_width_lp-1:0] a_addr_i,
  input  logic [width_p-1:0]       a_data_i,
  input  logic [mask_width_lp-1:0] a_mask_i,
  output logic                     a_ready_o,
  output logic [width_p-1:0]       a_data_o,
  output logic                     a_v_o,
  input  logic                     a_ready_i,

  input  logic                     b_v_i,
  input  logic                     b_w_i,
  input  logic [addr_width_lp-1:0] b_addr_i,
  input  logic [width_p-1:0]       b_data_i,
  input  logic [mask_width_lp-1:0] b_mask_i,
  output logic                     b_ready_o,
  output logic [width_p-1:0]       b_data_o,
  output logic                     b_v_o,
  input  logic                     b_ready_i,

  output logic                     mem_a_v_o,
  output logic                     mem_a_w_o,
  output logic [addr_width_lp-1:0] mem_a_addr_o,
  output logic [width_p-1:0]       mem_a_data_o,
  output logic [mask_width_lp-1:0] mem_a_w_mask_o,
  input  logic [width_p-1:0]       mem_a_data_i,

  output logic                     mem_b_v_o,
  output logic                     mem_b_w_o,
  output logic [addr_width_lp-1:0] mem_b_addr_o,
  output logic [width_p-1:0]       mem_b_data_o,
  output logic [mask_width_lp-1:0] mem_b_w_mask_o,
  input  logic [width_p-1:0]       mem_b_data_i
);

  localparam int cnt_w = $clog2(resp_els_p + 1);
  localparam int ptr_w = $clog2(resp_els_p);

  typedef logic [cnt_w:0] sum_t;

  logic [cnt_w-1:0]   count_q  [2];
  logic [ptr_w-1:0]   wr_ptr_q [2];
  logic [ptr_w-1:0]   rd_ptr_q [2];
  logic [width_p-1:0] fifo_q   [2][resp_els_p];
  logic [1:0]         in_flight_q;

  logic [width_p-1:0] ram_data [2];
  logic [1:0]         credit;
  logic [1:0]         issue_rd;
  logic [1:0]         deq;
  logic               collide;

  assign ram_data[0] = mem_a_data_i;
  assign ram_data[1] = mem_b_data_i;

  function automatic logic [ptr_w-1:0] nxt(
    input logic [ptr_w-1:0] x
  );
    return (x == ptr_w'(resp_els_p - 1)) ? '0 : x + 1'b1;
  endfunction

  // read credit: queued plus in-flight responses must leave a free slot
  always_comb begin
    credit = '0;
    for (int p = 0; p < 2; p++) begin
      credit[p] = (sum_t'(count_q[p]) + sum_t'(in_flight_q[p]))
                < sum_t'(resp_els_p);
    end
  end

  assign collide = a_v_i & b_v_i
                 & (a_addr_i == b_addr_i)
                 & (a_w_i | b_w_i);

  assign a_ready_o = reset_n_i & (a_w_i | credit[0]);
  assign b_ready_o = reset_n_i & ~collide
                   & (b_w_i | credit[1]);

  assign mem_a_v_o      = a_v_i & a_ready_o;
  assign mem_a_w_o      = a_w_i & a_ready_o;
  assign mem_a_addr_o   = a_addr_i;
  assign mem_a_data_o   = a_data_i;
  assign mem_a_w_mask_o = a_mask_i;

  assign mem_b_v_o      = b_v_i & b_ready_o;
  assign mem_b_w_o      = b_w_i & b_ready_o;
  assign mem_b_addr_o   = b_addr_i;
  assign mem_b_data_o   = b_data_i;
  assign mem_b_w_mask_o = b_mask_i;

  assign issue_rd[0] = mem_a_v_o & ~a_w_i;
  assign issue_rd[1] = mem_b_v_o & ~b_w_i;

  assign a_v_o    = reset_n_i & (count_q[0] != '0);
  assign b_v_o    = reset_n_i & (count_q[1] != '0);
  assign a_data_o = fifo_q[0][rd_ptr_q[0]];
  assign b_data_o = fifo_q[1][rd_ptr_q[1]];

  assign deq[0] = a_v_o & a_ready_i;
  assign deq[1] = b_v_o & b_ready_i;

  // track reads in flight and capture late RAM data into the FIFOs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_flight_q <= '0;
      for (int p = 0; p < 2; p++) begin
        count_q[p]  <= '0;
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        for (int i = 0; i < resp_els_p; i++) begin
          fifo_q[p][i] <= '0;
        end
      end
    end else begin
      in_flight_q <= issue_rd;
      for (int p = 0; p < 2; p++) begin
        if (in_flight_q[p]) begin
          fifo_q[p][wr_ptr_q[p]] <= ram_data[p];
          wr_ptr_q[p] <= nxt(wr_ptr_q[p]);
        end
        if (deq[p]) begin
          rd_ptr_q[p] <= nxt(rd_ptr_q[p]);
        end
        unique case ({in_flight_q[p], deq[p]})
          2'b10:   count_q[p] <= count_q[p] + 1'b1;
          2'b01:   count_q[p] <= count_q[p] - 1'b1;
          default: count_q[p] <= count_q[p];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bsg_mem_2rw_sync_mask_write_byte_ctrl.sv
// Scoreboard bench for the dual-port RAM controller.
// Includes a behavioural byte-masked sync RAM on the mem side.
module tb_bsg_mem_2rw_sync_mask_write_byte_ctrl;

  logic clk = 1'b0;
  logic reset_n_i;
  logic a_v_i, a_w_i, a_ready_i;
  logic [3:0] a_addr_i, a_mask_i;
  logic [31:0] a_data_i;
  logic b_v_i, b_w_i, b_ready_i;
  logic [3:0] b_addr_i, b_mask_i;
  logic [31:0] b_data_i;
  logic a_ready_o, a_v_o, b_ready_o, b_v_o;
  logic [31:0] a_data_o, b_data_o;
  logic mem_a_v_o, mem_a_w_o, mem_b_v_o, mem_b_w_o;
  logic [3:0] mem_a_addr_o, mem_b_addr_o;
  logic [3:0] mem_a_w_mask_o, mem_b_w_mask_o;
  logic [31:0] mem_a_data_o, mem_b_data_o;
  logic [31:0] mem_a_data_i, mem_b_data_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ram [16];
  logic [31:0] mdl [16];

  always #5 clk = ~clk;

  bsg_mem_2rw_sync_mask_write_byte_ctrl #(
    .width_p(32), .els_p(16), .resp_els_p(3)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .a_v_i(a_v_i), .a_w_i(a_w_i), .a_addr_i(a_addr_i),
    .a_data_i(a_data_i), .a_mask_i(a_mask_i),
    .a_ready_o(a_ready_o), .a_data_o(a_data_o),
    .a_v_o(a_v_o), .a_ready_i(a_ready_i),
    .b_v_i(b_v_i), .b_w_i(b_w_i), .b_addr_i(b_addr_i),
    .b_data_i(b_data_i), .b_mask_i(b_mask_i),
    .b_ready_o(b_ready_o), .b_data_o(b_data_o),
    .b_v_o(b_v_o), .b_ready_i(b_ready_i),
    .mem_a_v_o(mem_a_v_o), .mem_a_w_o(mem_a_w_o),
    .mem_a_addr_o(mem_a_addr_o), .mem_a_data_o(mem_a_data_o),
    .mem_a_w_mask_o(mem_a_w_mask_o), .mem_a_data_i(mem_a_data_i),
    .mem_b_v_o(mem_b_v_o), .mem_b_w_o(mem_b_w_o),
    .mem_b_addr_o(mem_b_addr_o), .mem_b_data_o(mem_b_data_o),
    .mem_b_w_mask_o(mem_b_w_mask_o), .mem_b_data_i(mem_b_data_i)
  );

  // behavioural RAM: masked writes, registered reads
  always @(posedge clk) begin
    if (mem_a_v_o) begin
      if (mem_a_w_o) begin
        for (int i = 0; i < 4; i++)
          if (mem_a_w_mask_o[i])
            ram[mem_a_addr_o][8*i +: 8] <= mem_a_data_o[8*i +: 8];
      end else begin
        mem_a_data_i <= ram[mem_a_addr_o];
      end
    end
    if (mem_b_v_o) begin
      if (mem_b_w_o) begin
        for (int i = 0; i < 4; i++)
          if (mem_b_w_mask_o[i])
            ram[mem_b_addr_o][8*i +: 8] <= mem_b_data_o[8*i +: 8];
      end else begin
        mem_b_data_i <= ram[mem_b_addr_o];
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pop expected data whenever a response is consumed
  always @(negedge clk) begin
    if (reset_n_i === 1'b1) begin
      if (a_v_o && a_ready_i) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: got %h expected none", a_data_o);
        end else chk("a_resp", a_data_o, qa.pop_front());
      end
      if (b_v_o && b_ready_i) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got %h expected none", b_data_o);
        end else chk("b_resp", b_data_o, qb.pop_front());
      end
      if (dut.count_q[0] > 3 || dut.count_q[1] > 3) begin
        checks++; errors++;
        $display("FAIL fifo_overflow: got %0d/%0d expected <=3",
                 dut.count_q[0], dut.count_q[1]);
      end
    end
  end

  task automatic a_req(input logic w, input logic [3:0] addr,
                       input logic [31:0] data, input logic [3:0] mask,
                       input logic [31:0] exp);
    a_v_i = 1; a_w_i = w; a_addr_i = addr;
    a_data_i = data; a_mask_i = mask;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_ready_o) break;
    end
    if (!a_ready_o) chk("a_req_timeout", 32'(a_ready_o), 32'd1);
    else if (!w) qa.push_back(exp);
    @(posedge clk); #1;
    a_v_i = 0;
  endtask

  task automatic b_req(input logic w, input logic [3:0] addr,
                       input logic [31:0] data, input logic [3:0] mask,
                       input logic [31:0] exp);
    b_v_i = 1; b_w_i = w; b_addr_i = addr;
    b_data_i = data; b_mask_i = mask;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_ready_o) break;
    end
    if (!b_ready_o) chk("b_req_timeout", 32'(b_ready_o), 32'd1);
    else if (!w) qb.push_back(exp);
    @(posedge clk); #1;
    b_v_i = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (qa.size() != 0 || qb.size() != 0)
      chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  logic [3:0]  bp_addr [5];
  logic [31:0] bp_exp  [5];
  int idx;
  int stale;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    mem_a_data_i = '0; mem_b_data_i = '0;
    reset_n_i = 0;
    a_v_i = 1; a_w_i = 0; a_addr_i = 0; a_data_i = 0; a_mask_i = 0;
    b_v_i = 1; b_w_i = 0; b_addr_i = 1; b_data_i = 0; b_mask_i = 0;
    a_ready_i = 1; b_ready_i = 1;
    #12;
    chk("rst_a_ready", 32'(a_ready_o), 0);
    chk("rst_b_ready", 32'(b_ready_o), 0);
    chk("rst_mem_a_v", 32'(mem_a_v_o), 0);
    chk("rst_mem_b_v", 32'(mem_b_v_o), 0);
    chk("rst_a_v", 32'(a_v_o), 0);
    chk("rst_b_v", 32'(b_v_o), 0);
    a_v_i = 0; b_v_i = 0;
    @(negedge clk); reset_n_i = 1;
    @(posedge clk); #1;

    // latency: write then read, data two cycles after handshake
    a_req(1, 5, 32'hDEADBEEF, 4'hF, 0);
    a_v_i = 1; a_w_i = 0; a_addr_i = 5;
    @(negedge clk);
    chk("lat_ready", 32'(a_ready_o), 1);
    qa.push_back(32'hDEADBEEF);
    @(posedge clk); #1; a_v_i = 0;
    @(negedge clk);
    chk("lat_t1_v", 32'(a_v_o), 0);
    @(negedge clk);
    chk("lat_t2_v", 32'(a_v_o), 1);
    chk("lat_t2_data", a_data_o, 32'hDEADBEEF);
    drain();

    // byte mask, and zero-mask write is a no-op
    a_req(1, 3, 32'h11223344, 4'hF, 0);
    a_req(1, 3, 32'hAABBCCDD, 4'b0101, 0);
    a_req(0, 3, 0, 0, 32'h11BB33DD);
    a_req(1, 3, 32'hFFFFFFFF, 4'h0, 0);
    a_req(0, 3, 0, 0, 32'h11BB33DD);
    drain();

    // collision: A write vs B read on addr 7
    a_v_i = 1; a_w_i = 1; a_addr_i = 7;
    a_data_i = 32'h55667788; a_mask_i = 4'hF;
    b_v_i = 1; b_w_i = 0; b_addr_i = 7;
    @(negedge clk);
    chk("col_b_ready", 32'(b_ready_o), 0);
    chk("col_a_ready", 32'(a_ready_o), 1);
    chk("col_mem_a_v", 32'(mem_a_v_o), 1);
    chk("col_mem_b_v", 32'(mem_b_v_o), 0);
    @(posedge clk); #1; a_v_i = 0;
    @(negedge clk);
    chk("col_b_retry", 32'(b_ready_o), 1);
    if (b_ready_o) qb.push_back(32'h55667788);
    @(posedge clk); #1; b_v_i = 0;
    a_v_i = 1; a_w_i = 0; a_addr_i = 7;
    b_v_i = 1; b_w_i = 0; b_addr_i = 7;
    @(negedge clk);
    chk("rr_a_ready", 32'(a_ready_o), 1);
    chk("rr_b_ready", 32'(b_ready_o), 1);
    if (a_ready_o) qa.push_back(32'h55667788);
    if (b_ready_o) qb.push_back(32'h55667788);
    @(posedge clk); #1; a_v_i = 0; b_v_i = 0;
    drain();

    // reset in the middle of outstanding reads
    a_ready_i = 0;
    a_v_i = 1; a_w_i = 0; a_addr_i = 5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_accept", 32'(a_ready_o), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mr_pre_v", 32'(a_v_o), 1);
    chk("mr_pre_ready", 32'(a_ready_o), 0);
    #1 reset_n_i = 0;
    #1;
    chk("mr_rst_v", 32'(a_v_o), 0);
    chk("mr_rst_ready", 32'(a_ready_o), 0);
    chk("mr_rst_mem_v", 32'(mem_a_v_o), 0);
    a_v_i = 0;
    @(negedge clk); reset_n_i = 1; a_ready_i = 1;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_v_o) stale++;
    end
    chk("mr_no_stale", 32'(stale), 0);
    a_v_i = 1; a_w_i = 0;
    #1;
    chk("mr_post_ready", 32'(a_ready_o), 1);
    a_v_i = 0;
    @(posedge clk); #1;

    // backpressure on B
    b_req(1, 8, 32'h80808080, 4'hF, 0);
    b_req(1, 9, 32'h90909090, 4'hF, 0);
    bp_addr[0] = 5; bp_exp[0] = 32'hDEADBEEF;
    bp_addr[1] = 3; bp_exp[1] = 32'h11BB33DD;
    bp_addr[2] = 7; bp_exp[2] = 32'h55667788;
    bp_addr[3] = 8; bp_exp[3] = 32'h80808080;
    bp_addr[4] = 9; bp_exp[4] = 32'h90909090;
    b_ready_i = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      b_v_i = 1; b_w_i = 0; b_addr_i = bp_addr[idx];
      @(negedge clk);
      if (b_ready_o) begin qb.push_back(bp_exp[idx]); idx++; end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(idx), 3);
    @(negedge clk);
    chk("bp_stalled", 32'(b_ready_o), 0);
    @(posedge clk); #1;
    b_ready_i = 1;
    for (int c = 0; c < 50 && idx < 5; c++) begin
      b_v_i = 1; b_w_i = 0; b_addr_i = bp_addr[idx];
      @(negedge clk);
      if (b_ready_o) begin qb.push_back(bp_exp[idx]); idx++; end
      @(posedge clk); #1;
    end
    b_v_i = 0;
    chk("bp_all", 32'(idx), 5);
    drain();

    // throughput: back-to-back reads on both ports
    for (int i = 0; i < 16; i++) begin
      mdl[i] = 32'h10000000 + i * 32'h01010101;
      a_req(1, 4'(i), mdl[i], 4'hF, 0);
    end
    for (int c = 0; c < 300; c++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      a_v_i = 1; a_w_i = 0; a_addr_i = ra;
      b_v_i = 1; b_w_i = 0; b_addr_i = rb;
      @(negedge clk);
      chk("tp_a_ready", 32'(a_ready_o), 1);
      chk("tp_b_ready", 32'(b_ready_o), 1);
      if (a_ready_o) qa.push_back(mdl[ra]);
      if (b_ready_o) qb.push_back(mdl[rb]);
      @(posedge clk); #1;
    end
    a_v_i = 0; b_v_i = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
